// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the clearable dual-port RAM.
// The sweep length helper lets the top compute its final sweep address at elaboration.
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dp_ram_state_e;

  localparam int MAX_RD_LATENCY = 2;

  function automatic int clr_cycles(input int addr_w);
    return (addr_w == 0) ? 1 : (1 << (addr_w - 1));
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read return pipe for one port: rd_vld_i -> rvalid_o after RD_LATENCY (1 or 2) cycles.
// No backpressure; one result per cycle. rdata_o holds the last valid result.
module dp_ram_rd_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_vld_i,
  input  logic [DATA_WIDTH-1:0] rd_dat_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o
);
  import dp_ram_pkg::*;

  logic [MAX_RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]     dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[MAX_RD_LATENCY-2:0], rd_vld_i};
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           dat_q <= '0;
        else if (rd_vld_i) dat_q <= rd_dat_i;
      end
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] stg_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg_q <= '0;
          dat_q <= '0;
        end else begin
          if (rd_vld_i) stg_q <= rd_dat_i;
          if (vld_q[0]) dat_q <= stg_q;
        end
      end
    end
  endgenerate

  assign rvalid_o = vld_q[RD_LATENCY-1];
  assign rdata_o  = dat_q;

endmodule

// File: rtl/dp_ram_clr.sv
// True dual-port RAM with a hardware clear sweep after reset or on clr_req; read-first, port A wins.
// Reads return after RD_LATENCY cycles; user accesses are dropped while ready=0. DP_RAM_CLR_COLL_EN adds coll.
module dp_ram_clr #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RD_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  ready,
  output logic                  clr_done,
  input  logic                  we_a,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic                  we_b,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b
`ifdef DP_RAM_CLR_COLL_EN
  ,
  output logic                  coll
`endif
);
  import dp_ram_pkg::*;

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam int                    SWEEP     = clr_cycles(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(2 * (SWEEP - 1));

  dp_ram_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  sweep_last;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_en_a, wr_en_b;
  logic [ADDR_WIDTH-1:0] wr_addr_a, wr_addr_b;
  logic [DATA_WIDTH-1:0] wr_dat_a, wr_dat_b;
  logic                  rd_acc_a, rd_acc_b;

  assign sweep_last = (state_q == CLEAR) && (clr_addr_q == LAST_ADDR);
  assign ready      = (state_q == IDLE);
  assign clr_done   = sweep_last && !rst;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(2);
        if (sweep_last) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // The sweep owns both write ports; user traffic only reaches the array when idle.
  always_comb begin
    if (state_q == CLEAR) begin
      wr_en_a   = 1'b1;
      wr_addr_a = clr_addr_q;
      wr_dat_a  = CLR_VALUE;
      wr_en_b   = 1'b1;
      wr_addr_b = clr_addr_q + ADDR_WIDTH'(1);
      wr_dat_b  = CLR_VALUE;
    end else begin
      wr_en_a   = we_a;
      wr_addr_a = addr_a;
      wr_dat_a  = wdata_a;
      wr_en_b   = we_b;
      wr_addr_b = addr_b;
      wr_dat_b  = wdata_b;
    end
  end

  assign rd_acc_a = ready && re_a;
  assign rd_acc_b = ready && re_b;

  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en_b) mem_q[wr_addr_b] <= wr_dat_b;
    if (wr_en_a) mem_q[wr_addr_a] <= wr_dat_a;
  end

  dp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe_a (
    .clk      (clk),
    .rst      (rst),
    .rd_vld_i (rd_acc_a),
    .rd_dat_i (mem_q[addr_a]),
    .rdata_o  (rdata_a),
    .rvalid_o (rvalid_a)
  );

  dp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe_b (
    .clk      (clk),
    .rst      (rst),
    .rd_vld_i (rd_acc_b),
    .rd_dat_i (mem_q[addr_b]),
    .rdata_o  (rdata_b),
    .rvalid_o (rvalid_b)
  );

`ifdef DP_RAM_CLR_COLL_EN
  logic coll_q, coll_d;

  always_comb begin
    coll_d = ready && (addr_a == addr_b) &&
             ((we_a && we_b) || (we_a && re_b) || (we_b && re_a));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_d;
  end

  assign coll = coll_q;
`endif

endmodule

// File: tb/tb_dp_ram_clr.sv
// Directed bench for dp_ram_clr at default parameters (16-bit, 256 words, read latency 2).
module tb_dp_ram_clr;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          ready, clr_done;
  logic          we_a, re_a, we_b, re_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b;
`ifdef DP_RAM_CLR_COLL_EN
  logic          coll;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_ram_clr #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT),
    .CLR_VALUE  (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_done (clr_done),
    .we_a     (we_a),
    .re_a     (re_a),
    .addr_a   (addr_a),
    .wdata_a  (wdata_a),
    .rdata_a  (rdata_a),
    .rvalid_a (rvalid_a),
    .we_b     (we_b),
    .re_b     (re_b),
    .addr_b   (addr_b),
    .wdata_b  (wdata_b),
    .rdata_b  (rdata_b),
    .rvalid_b (rvalid_b)
`ifdef DP_RAM_CLR_COLL_EN
    ,
    .coll     (coll)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 0; we_a = 0; re_a = 0; we_b = 0; re_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic wr2(input logic ea, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic eb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    we_a = ea; addr_a = aa; wdata_a = da;
    we_b = eb; addr_b = ab; wdata_b = db;
    tick();
    we_a = 0; we_b = 0;
  endtask

  task automatic rd(input bit pb, input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    if (pb) begin re_b = 1; addr_b = a; end
    else    begin re_a = 1; addr_a = a; end
    tick();
    re_a = 0; re_b = 0;
    lat = 1;
    while (!(pb ? rvalid_b : rvalid_a) && lat < 8) begin
      tick();
      lat++;
    end
    d = pb ? rdata_b : rdata_a;
  endtask

  // Counts sweep cycles until ready; optionally pokes clr_req and user traffic mid-sweep.
  task automatic sweep_wait(input bit inject, output int n, output int done_at,
                            output int done_cnt, output int rv_seen);
    n = 0; done_at = 0; done_cnt = 0; rv_seen = 0;
    while (!ready && n < 400) begin
      n++;
      if (clr_done) begin done_at = n; done_cnt++; end
      if (rvalid_a || rvalid_b) rv_seen++;
      if (inject) begin
        clr_req = (n == 60);
        if (n == 100) begin
          we_a = 1; addr_a = 8'h02; wdata_a = 16'hDEAD;
          we_b = 1; addr_b = 8'h04; wdata_b = 16'hBEEF;
        end else if (n == 101) begin
          we_a = 0; we_b = 0;
          re_a = 1; addr_a = 8'h02; re_b = 1; addr_b = 8'h04;
        end else begin
          we_a = 0; we_b = 0; re_a = 0; re_b = 0;
        end
      end
      tick();
    end
    clr_req = 0; re_a = 0; re_b = 0;
    for (int k = 0; k < LAT + 1; k++) begin
      if (rvalid_a || rvalid_b) rv_seen++;
      tick();
    end
  endtask

  logic [DW-1:0] d;
  int            lat, n, done_at, done_cnt, rv_seen;
  logic [DW-1:0] got_q[$];

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_rdata_b", rdata_b, 0);
`ifdef DP_RAM_CLR_COLL_EN
    check("rst_coll", coll, 0);
`endif

    // 1: power-up sweep
    rst = 0;
    #1;
    sweep_wait(0, n, done_at, done_cnt, rv_seen);
    check("t1_sweep_cycles", n, 128);
    check("t1_done_cycle", done_at, 128);
    check("t1_done_pulses", done_cnt, 1);
    rd(0, 8'h00, d, lat); check("t1_rd_00", d, 16'h0000);
    check("t1_lat_a", lat, 2);
    rd(0, 8'h7F, d, lat); check("t1_rd_7f", d, 16'h0000);
    rd(1, 8'hFF, d, lat); check("t1_rd_ff", d, 16'h0000);

    // 2: write A, read B next cycle
    wr2(1, 8'h10, 16'hBEEF, 0, 8'h00, 16'h0000);
    rd(1, 8'h10, d, lat);
    check("t2_rd_10", d, 16'hBEEF);
    check("t2_lat_b", lat, 2);
    tick();
    check("t2_rvalid_one_cycle", rvalid_b, 0);

    // 3: write collision, A wins
    wr2(1, 8'h20, 16'h1111, 1, 8'h20, 16'h2222);
`ifdef DP_RAM_CLR_COLL_EN
    check("t3_coll_set", coll, 1);
    tick();
    check("t3_coll_clear", coll, 0);
`endif
    rd(0, 8'h20, d, lat); check("t3_rd_20", d, 16'h1111);

    // 4: cross-port read-first, then same-port write+read
    wr2(1, 8'h30, 16'hAAAA, 0, 8'h00, 16'h0000);
    we_a = 1; addr_a = 8'h30; wdata_a = 16'h5555; re_b = 1; addr_b = 8'h30;
    tick();
    we_a = 0; re_b = 0;
`ifdef DP_RAM_CLR_COLL_EN
    check("t4_coll_wr_rd", coll, 1);
`endif
    tick();
    check("t4_rvalid_b", rvalid_b, 1);
    check("t4_read_first", rdata_b, 16'hAAAA);
    rd(0, 8'h30, d, lat); check("t4_rd_after", d, 16'h5555);
    we_a = 1; re_a = 1; addr_a = 8'h31; wdata_a = 16'h1234;
    tick();
    we_a = 0; re_a = 0;
    tick();
    check("t4_same_port_old", rdata_a, 16'h0000);
    rd(1, 8'h31, d, lat); check("t4_same_port_new", d, 16'h1234);

    // 5: fill, clear request, reset mid-sweep, traffic during sweep
    for (int i = 0; i < 16; i += 2)
      wr2(1, AW'(i), DW'(16'h0100 + i), 1, AW'(i + 1), DW'(16'h0101 + i));
    rd(0, 8'h07, d, lat); check("t5_fill_07", d, 16'h0107);
    clr_req = 1;
    tick();
    clr_req = 0;
    check("t5_ready_low", ready, 0);
    repeat (49) tick();
    rst = 1;
    tick();
    check("t5_rst_rdata_a", rdata_a, 0);
    check("t5_rst_ready", ready, 0);
    tick();
    rst = 0;
    #1;
    sweep_wait(1, n, done_at, done_cnt, rv_seen);
    check("t5_restart_cycles", n, 128);
    check("t5_restart_done", done_at, 128);
    check("t5_no_rvalid", rv_seen, 0);
    rd(0, 8'h00, d, lat); check("t5_rd_00", d, 16'h0000);
    rd(1, 8'h0F, d, lat); check("t5_rd_0f", d, 16'h0000);
    rd(0, 8'h02, d, lat); check("t5_dropped_wr_a", d, 16'h0000);
    rd(1, 8'h04, d, lat); check("t5_dropped_wr_b", d, 16'h0000);
    rd(0, 8'h10, d, lat); check("t5_rd_10", d, 16'h0000);

    // 6: back-to-back reads
    for (int i = 0; i < 16; i += 2)
      wr2(1, AW'(i), DW'(16'hC000 + i * 16'h11), 1, AW'(i + 1), DW'(16'hC000 + (i + 1) * 16'h11));
    n = 0; done_at = -1; done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      re_a = (c < 16);
      addr_a = AW'(c);
      tick();
      if (rvalid_a) begin
        got_q.push_back(rdata_a);
        if (done_at < 0) done_at = c;
        done_cnt = c;
      end
    end
    re_a = 0;
    check("t6_count", got_q.size(), 16);
    check("t6_first_cycle", done_at, 1);
    check("t6_contiguous", done_cnt - done_at, 15);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) check($sformatf("t6_data_%0d", i), got_q[i], 16'hC000 + i * 16'h11);
      else                  check($sformatf("t6_data_%0d", i), 32'hFFFF_FFFF, 16'hC000 + i * 16'h11);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
